// File: rtl/dcache_miss_handler_if.sv
// Pipeline, cache and main-memory signal bundle for the data-cache miss handler.
// The slave modport is the handler itself; master is the surrounding system.
interface dcache_miss_handler_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  lookup_valid;
   logic                  lookup_we;
   logic [ADDR_WIDTH-1:0] lookup_addr;
   logic [DATA_WIDTH-1:0] lookup_wdata;
   logic                  cache_hit;
   logic [DATA_WIDTH-1:0] cache_rdata;
   logic                  stall;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  rdata_valid;
   logic                  fill_valid;
   logic [ADDR_WIDTH-1:0] fill_addr;
   logic [DATA_WIDTH-1:0] fill_data;
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_ack;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic [31:0]           hit_count;
   logic [31:0]           miss_count;

   modport slave (
      input  lookup_valid, lookup_we, lookup_addr, lookup_wdata,
      input  cache_hit, cache_rdata, mem_ack, mem_rdata,
      output stall, rdata, rdata_valid, fill_valid, fill_addr, fill_data,
      output mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
   );

   modport master (
      output lookup_valid, lookup_we, lookup_addr, lookup_wdata,
      output cache_hit, cache_rdata, mem_ack, mem_rdata,
      input  stall, rdata, rdata_valid, fill_valid, fill_addr, fill_data,
      input  mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
   );
endinterface

// File: rtl/dcache_miss_handler.sv
// Data-cache miss handler: serves load hits combinationally, runs memory
// transactions for load misses and write-through stores, refills the cache.
//
// state     | meaning
// S_IDLE    | accept a lookup; hits answered same cycle
// S_RD_REQ  | read request outstanding for a load miss
// S_FILL    | write fetched word into cache and return it
// S_WR_REQ  | write-through request outstanding
// S_WR_DONE | release pipeline; update cache only if the store hit
module dcache_miss_handler #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input logic                   clk,
   input logic                   rst_n,
   dcache_miss_handler_if.slave  bus
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_REQ,
      S_FILL,
      S_WR_REQ,
      S_WR_DONE
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_hit;
   logic                  r_mem_req;
   logic                  r_mem_we;
   logic [31:0]           r_hit_cnt;
   logic [31:0]           r_miss_cnt;

   logic                  w_idle;
   logic                  w_load_hit;
   logic                  w_load_miss;
   logic                  w_store;
   logic                  w_fill;
   logic [ADDR_WIDTH-1:0] w_addr_aligned;

   assign w_idle         = (r_state == S_IDLE);
   assign w_load_hit     = w_idle & bus.lookup_valid & ~bus.lookup_we &  bus.cache_hit;
   assign w_load_miss    = w_idle & bus.lookup_valid & ~bus.lookup_we & ~bus.cache_hit;
   assign w_store        = w_idle & bus.lookup_valid &  bus.lookup_we;
   assign w_fill         = (r_state == S_FILL) | ((r_state == S_WR_DONE) & r_hit);
   assign w_addr_aligned = {bus.lookup_addr[ADDR_WIDTH-1:2], 2'b00};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_data     <= '0;
         r_hit      <= 1'b0;
         r_mem_req  <= 1'b0;
         r_mem_we   <= 1'b0;
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_load_hit) begin
                  r_hit_cnt <= r_hit_cnt + {31'd0, (r_hit_cnt != 32'hFFFF_FFFF)};
               end else if (w_load_miss) begin
                  r_addr     <= w_addr_aligned;
                  r_miss_cnt <= r_miss_cnt + {31'd0, (r_miss_cnt != 32'hFFFF_FFFF)};
                  r_mem_req  <= 1'b1;
                  r_mem_we   <= 1'b0;
                  r_state    <= S_RD_REQ;
               end else if (w_store) begin
                  r_addr    <= w_addr_aligned;
                  r_data    <= bus.lookup_wdata;
                  r_hit     <= bus.cache_hit;
                  r_mem_req <= 1'b1;
                  r_mem_we  <= 1'b1;
                  r_state   <= S_WR_REQ;
               end
            end
            S_RD_REQ: begin
               if (bus.mem_ack) begin
                  r_data    <= bus.mem_rdata;
                  r_mem_req <= 1'b0;
                  r_state   <= S_FILL;
               end
            end
            S_FILL:    r_state <= S_IDLE;
            S_WR_REQ: begin
               if (bus.mem_ack) begin
                  r_mem_req <= 1'b0;
                  r_state   <= S_WR_DONE;
               end
            end
            S_WR_DONE: r_state <= S_IDLE;
            default:   r_state <= S_IDLE;
         endcase
      end
   end

   // Hit path and stall are combinational so a load hit costs no cycle.
   assign bus.stall       = (w_idle & bus.lookup_valid & (bus.lookup_we | ~bus.cache_hit))
                          | (r_state == S_RD_REQ) | (r_state == S_WR_REQ);
   assign bus.rdata_valid = w_load_hit | (r_state == S_FILL);
   assign bus.rdata       = w_load_hit ? bus.cache_rdata :
                            (r_state == S_FILL) ? r_data : '0;
   assign bus.fill_valid  = w_fill;
   assign bus.fill_addr   = w_fill ? r_addr : '0;
   assign bus.fill_data   = w_fill ? r_data : '0;
   assign bus.mem_req     = r_mem_req;
   assign bus.mem_we      = r_mem_we;
   assign bus.mem_addr    = r_addr;
   assign bus.mem_wdata   = r_data;
   assign bus.hit_count   = r_hit_cnt;
   assign bus.miss_count  = r_miss_cnt;
endmodule

// File: tb/tb_dcache_miss_handler.sv
// Directed bench for dcache_miss_handler: hits, misses, stores, spurious ack,
// back-to-back misses and reset during an outstanding request.
module tb_dcache_miss_handler;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   int   stall_cycles;
   logic fv_seen;

   dcache_miss_handler_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

   dcache_miss_handler #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      bus_if.lookup_valid = 1'b0;
      bus_if.lookup_we    = 1'b0;
      bus_if.lookup_addr  = '0;
      bus_if.lookup_wdata = '0;
      bus_if.cache_hit    = 1'b0;
      bus_if.cache_rdata  = '0;
      bus_if.mem_ack      = 1'b0;
      bus_if.mem_rdata    = '0;

      // reset state
      #22;
      check_val("rst_stall", bus_if.stall, 0);
      check_val("rst_mem_req", bus_if.mem_req, 0);
      check_val("rst_rdata_valid", bus_if.rdata_valid, 0);
      check_val("rst_fill_valid", bus_if.fill_valid, 0);
      check_val("rst_hit_count", bus_if.hit_count, 0);
      check_val("rst_miss_count", bus_if.miss_count, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // load hit
      tick();
      bus_if.lookup_valid = 1'b1;
      bus_if.lookup_addr  = 32'h100;
      bus_if.cache_hit    = 1'b1;
      bus_if.cache_rdata  = 32'hDEADBEEF;
      #1;
      check_val("hit_rdata_valid", bus_if.rdata_valid, 1);
      check_val("hit_rdata", bus_if.rdata, 32'hDEADBEEF);
      check_val("hit_stall", bus_if.stall, 0);
      tick();
      bus_if.lookup_valid = 1'b0;
      bus_if.cache_hit    = 1'b0;
      bus_if.cache_rdata  = '0;
      #1;
      check_val("hit_count", bus_if.hit_count, 1);
      check_val("idle_rdata_zero", bus_if.rdata, 0);

      // load miss at 0x203, ack on the 4th RD_REQ cycle
      bus_if.lookup_valid = 1'b1;
      bus_if.lookup_addr  = 32'h203;
      #1;
      stall_cycles = 0;
      if (bus_if.stall) stall_cycles++;
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (c == 4) begin
            bus_if.mem_ack   = 1'b1;
            bus_if.mem_rdata = 32'h12345678;
         end
         #1;
         if (bus_if.stall) stall_cycles++;
         if (c == 1) begin
            check_val("miss_mem_req", bus_if.mem_req, 1);
            check_val("miss_mem_we", bus_if.mem_we, 0);
            check_val("miss_mem_addr", bus_if.mem_addr, 32'h200);
         end
         if (c == 4) begin
            check_val("miss_req_held", bus_if.mem_req, 1);
            check_val("miss_addr_held", bus_if.mem_addr, 32'h200);
         end
      end
      tick();
      bus_if.mem_ack      = 1'b0;
      bus_if.mem_rdata    = '0;
      bus_if.lookup_valid = 1'b0;
      #1;
      check_val("miss_stall_cycles", stall_cycles, 5);
      check_val("fill_stall", bus_if.stall, 0);
      check_val("fill_valid", bus_if.fill_valid, 1);
      check_val("fill_addr", bus_if.fill_addr, 32'h200);
      check_val("fill_data", bus_if.fill_data, 32'h12345678);
      check_val("fill_rdata", bus_if.rdata, 32'h12345678);
      check_val("fill_rdata_valid", bus_if.rdata_valid, 1);
      check_val("fill_mem_req", bus_if.mem_req, 0);
      check_val("miss_count", bus_if.miss_count, 1);

      // store hit at 0x40, ack on the 2nd WR_REQ cycle
      tick();
      bus_if.lookup_valid = 1'b1;
      bus_if.lookup_we    = 1'b1;
      bus_if.lookup_addr  = 32'h40;
      bus_if.lookup_wdata = 32'hA5A5A5A5;
      bus_if.cache_hit    = 1'b1;
      #1;
      check_val("st_stall", bus_if.stall, 1);
      tick();
      check_val("st_mem_req", bus_if.mem_req, 1);
      check_val("st_mem_we", bus_if.mem_we, 1);
      check_val("st_mem_wdata", bus_if.mem_wdata, 32'hA5A5A5A5);
      check_val("st_mem_addr", bus_if.mem_addr, 32'h40);
      check_val("st_no_early_fill", bus_if.fill_valid, 0);
      tick();
      bus_if.mem_ack = 1'b1;
      #1;
      check_val("st_req_held", bus_if.mem_req, 1);
      check_val("st_stall_held", bus_if.stall, 1);
      tick();
      bus_if.mem_ack      = 1'b0;
      bus_if.lookup_valid = 1'b0;
      bus_if.lookup_we    = 1'b0;
      bus_if.cache_hit    = 1'b0;
      #1;
      check_val("wd_fill_valid", bus_if.fill_valid, 1);
      check_val("wd_fill_data", bus_if.fill_data, 32'hA5A5A5A5);
      check_val("wd_fill_addr", bus_if.fill_addr, 32'h40);
      check_val("wd_rdata_valid", bus_if.rdata_valid, 0);
      check_val("wd_rdata", bus_if.rdata, 0);
      check_val("wd_stall", bus_if.stall, 0);
      check_val("st_hit_count", bus_if.hit_count, 1);

      // store miss at 0x80, ack on the 1st WR_REQ cycle
      tick();
      bus_if.lookup_valid = 1'b1;
      bus_if.lookup_we    = 1'b1;
      bus_if.lookup_addr  = 32'h80;
      bus_if.lookup_wdata = 32'h0F0F0F0F;
      #1;
      fv_seen = bus_if.fill_valid;
      tick();
      bus_if.mem_ack = 1'b1;
      #1;
      fv_seen |= bus_if.fill_valid;
      check_val("sm_mem_we", bus_if.mem_we, 1);
      check_val("sm_mem_addr", bus_if.mem_addr, 32'h80);
      check_val("sm_mem_wdata", bus_if.mem_wdata, 32'h0F0F0F0F);
      tick();
      bus_if.mem_ack      = 1'b0;
      bus_if.lookup_valid = 1'b0;
      bus_if.lookup_we    = 1'b0;
      #1;
      fv_seen |= bus_if.fill_valid;
      check_val("sm_done_stall", bus_if.stall, 0);
      tick();
      fv_seen |= bus_if.fill_valid;
      check_val("sm_no_fill", fv_seen, 0);
      check_val("sm_miss_count", bus_if.miss_count, 1);

      // spurious ack in IDLE
      bus_if.mem_ack = 1'b1;
      tick();
      bus_if.mem_ack = 1'b0;
      #1;
      check_val("spur_mem_req", bus_if.mem_req, 0);
      check_val("spur_stall", bus_if.stall, 0);
      check_val("spur_fill", bus_if.fill_valid, 0);

      // back-to-back load misses
      bus_if.lookup_valid = 1'b1;
      bus_if.lookup_addr  = 32'h300;
      #1;
      check_val("b2b_stall0", bus_if.stall, 1);
      tick();
      bus_if.mem_ack   = 1'b1;
      bus_if.mem_rdata = 32'h11112222;
      #1;
      check_val("b2b_addr0", bus_if.mem_addr, 32'h300);
      tick();
      bus_if.mem_ack     = 1'b0;
      bus_if.mem_rdata   = '0;
      bus_if.lookup_addr = 32'h404;
      #1;
      check_val("b2b_fill_rdata", bus_if.rdata, 32'h11112222);
      check_val("b2b_fill_stall", bus_if.stall, 0);
      check_val("b2b_fill_addr", bus_if.fill_addr, 32'h300);
      tick();
      check_val("b2b_idle_stall", bus_if.stall, 1);
      tick();
      check_val("b2b_mem_req", bus_if.mem_req, 1);
      check_val("b2b_mem_addr", bus_if.mem_addr, 32'h404);
      check_val("b2b_miss_count", bus_if.miss_count, 3);

      // reset while the read request is outstanding
      #2;
      bus_if.lookup_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check_val("arst_mem_req", bus_if.mem_req, 0);
      check_val("arst_stall", bus_if.stall, 0);
      check_val("arst_miss_count", bus_if.miss_count, 0);
      check_val("arst_hit_count", bus_if.hit_count, 0);
      @(negedge clk);
      bus_if.mem_ack = 1'b1;
      @(negedge clk);
      bus_if.mem_ack = 1'b0;
      rst_n = 1'b1;
      tick();
      check_val("post_rst_fill", bus_if.fill_valid, 0);
      check_val("post_rst_mem_req", bus_if.mem_req, 0);
      check_val("post_rst_mem_addr", bus_if.mem_addr, 0);
      check_val("post_rst_rdata_valid", bus_if.rdata_valid, 0);
      check_val("post_rst_miss_count", bus_if.miss_count, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
